// File: rtl/counter_preload_sequencer.sv
// Sequencer for the serially preloaded up/down counter. It shifts a captured
// preload MSB-first on a generated sclk, pulses load, then counts for run_len cycles.
module counter_preload_sequencer #(
  parameter int SCLK_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] preload_i,
  input  logic       dir_up_i,
  input  logic [7:0] run_len_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       sdi_o,
  output logic       sclk_o,
  output logic       load_o,
  output logic       up_o,
  output logic       en_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0] HALF_LAST = 4'(SCLK_HALF - 1);

  state_t     r_state;
  logic [7:0] r_preload;
  logic [7:0] r_run_len;
  logic [7:0] r_run_cnt;
  logic       r_dir;
  logic [2:0] r_bit;
  logic [3:0] r_hcnt;
  logic       w_half_end;

  assign w_half_end = (r_hcnt == HALF_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_preload <= '0;
      r_run_len <= '0;
      r_run_cnt <= '0;
      r_dir     <= 1'b0;
      r_bit     <= '0;
      r_hcnt    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      sdi_o     <= 1'b0;
      sclk_o    <= 1'b0;
      load_o    <= 1'b0;
      up_o      <= 1'b0;
      en_o      <= 1'b0;
    end else if (abort_i) begin
      // In IDLE everything is already quiet, so this also blocks a same-cycle start.
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sdi_o   <= 1'b0;
      sclk_o  <= 1'b0;
      load_o  <= 1'b0;
      up_o    <= 1'b0;
      en_o    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_preload <= preload_i;
            r_run_len <= run_len_i;
            r_dir     <= dir_up_i;
            r_bit     <= 3'd7;
            r_hcnt    <= '0;
            sdi_o     <= preload_i[7];
            sclk_o    <= 1'b0;
            busy_o    <= 1'b1;
            r_state   <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          if (w_half_end) begin
            r_hcnt  <= '0;
            sclk_o  <= 1'b1;
            r_state <= S_SHIFT_HI;
          end else begin
            r_hcnt <= r_hcnt + 4'd1;
          end
        end
        S_SHIFT_HI: begin
          if (w_half_end) begin
            r_hcnt <= '0;
            sclk_o <= 1'b0;
            if (r_bit != 3'd0) begin
              r_bit   <= r_bit - 3'd1;
              sdi_o   <= r_preload[r_bit - 3'd1];
              r_state <= S_SHIFT_LO;
            end else begin
              sdi_o   <= 1'b0;
              load_o  <= 1'b1;
              up_o    <= r_dir;
              r_state <= S_LOAD;
            end
          end else begin
            r_hcnt <= r_hcnt + 4'd1;
          end
        end
        S_LOAD: begin
          load_o <= 1'b0;
          if (r_run_len == 8'd0) begin
            done_o  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            en_o      <= 1'b1;
            r_run_cnt <= r_run_len;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          // Count reaches 1 on the final enabled cycle, so run_len cycles exactly.
          if (r_run_cnt == 8'd1) begin
            r_run_cnt <= '0;
            en_o      <= 1'b0;
            done_o    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_run_cnt <= r_run_cnt - 8'd1;
          end
        end
        S_DONE: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          up_o    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/counter_preload_sequencer.md
Name: counter_preload_sequencer

Overview:
Sequences the serially preloaded up/down counter datapath. On a start request it captures an 8-bit preload value and shifts it out MSB-first on a generated serial clock. It then pulses the counter's synchronous load, enables counting for a programmed number of clk cycles, and signals completion. It sits between the host-side control bits and the counter's load/sdi/sclk/up/en inputs, so the host no longer bit-bangs those pins.

Parameters:
SCLK_HALF, 2, clk cycles per sclk_o half-period (legal range 1..15)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
start_i  input  1  start request, sampled only in IDLE
abort_i  input  1  synchronous abort, any state
preload_i  input  8  value to shift into counter, captured at start
dir_up_i  input  1  count direction for RUN, captured at start (1 = up)
run_len_i  input  8  number of counting cycles, captured at start
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle completion pulse
sdi_o  output  1  serial data to counter shift register
sclk_o  output  1  serial shift clock to counter
load_o  output  1  counter synchronous load strobe
up_o  output  1  counter direction
en_o  output  1  counter count enable

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. All outputs 0: busy_o, done_o, sdi_o, sclk_o, load_o, up_o, en_o. Capture registers cleared. Reset mid-sequence aborts immediately and produces no done_o.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SHIFT_LO, SHIFT_HI, LOAD, RUN, DONE.
- IDLE:
  - If start_i=1, capture preload_i, dir_up_i and run_len_i, then go to SHIFT_LO with bit index 7.
  - start_i in any other state is ignored; nothing is queued.
- SHIFT_LO:
  - sclk_o=0 and sdi_o=preload[bit index], both held for SCLK_HALF cycles.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - sclk_o=1 and sdi_o held stable for SCLK_HALF cycles. sdi_o is therefore stable across the sclk_o rising edge.
  - Then, if bit index > 0: decrement the index and go to SHIFT_LO.
  - If bit index = 0: go to LOAD with sclk_o=0.
- Shift phase length: exactly 8 sclk_o rising edges and 16*SCLK_HALF clk cycles.
- LOAD: load_o=1 for exactly one cycle; sclk_o=0 and en_o=0.
  - If run_len=0, go to DONE; otherwise go to RUN.
- RUN:
  - en_o=1 and up_o=captured dir for exactly run_len cycles. An 8-bit down-counter reloads from run_len and reaches 0 without wrapping.
  - Then go to DONE.
- up_o holds the captured direction from LOAD through DONE and returns to 0 in IDLE.
- DONE: done_o=1 for one cycle, then go to IDLE; busy_o falls on the same edge.
- Timing from the start edge: busy_o rises 1 cycle later. First sclk_o rise is at cycle 1+SCLK_HALF. load_o is at cycle 1+16*SCLK_HALF. done_o is at cycle 2+16*SCLK_HALF+run_len.
- abort_i=1 (not in IDLE): next state IDLE and all outputs 0.
  - A partial shift is left in the counter's shift register and load_o is not issued.
  - Abort has priority over a state's own transition. Reset has priority over abort.
  - abort_i in IDLE has no effect; with start_i in the same cycle, abort wins.
- start_i held high continuously restarts a new sequence on the cycle after DONE, since IDLE lasts one cycle.
- Input changes after capture have no effect on an in-flight sequence.

Test Plan:
- Reset: hold rst for 3 cycles during a RUN phase -> all outputs 0 on the next cycle, state IDLE, no done_o pulse.
- Basic sequence, SCLK_HALF=2, preload=0xA5, run_len=3, dir=1, start pulse at cycle 0 ->
  - busy_o rises at cycle 1.
  - sdi_o values sampled at the 8 sclk_o rising edges = 1,0,1,0,0,1,0,1.
  - load_o at cycle 33, en_o at cycles 34–36 with up_o=1, done_o at cycle 37, busy_o=0 at cycle 38.
  - Bench counter model ends at 0xA8.
- Zero run length: preload=0x10, run_len=0, dir=0 -> en_o never asserts; done_o one cycle after load_o; model counter = 0x10.
- Down count with wrap: preload=0x01, run_len=3, dir=0 -> en_o for 3 cycles with up_o=0; model counter = 0xFE.
- Abort: assert abort_i during the 4th SHIFT_HI -> next cycle all outputs 0 and busy_o=0; no load_o, no done_o; a new start works normally afterwards.
- Start while busy, plus a back-to-back start: second start_i pulse during RUN is ignored, giving exactly one done_o. start_i held high -> second sequence begins with busy_o re-rising 2 cycles after the first done_o, using preload_i as sampled at that IDLE cycle.
